// File: rtl/fetch_unit_pkg.sv
// Shared widths, constants and helpers for the fetch unit and its branch predictor.
package fetch_unit_pkg;

    localparam int PC_W       = 16;
    localparam int PRED_DEPTH = 8;
    localparam int IDX_W      = 3;
    localparam int CNT_W      = 2;
    localparam int OPC_W      = 4;

    localparam logic [OPC_W-1:0] HLT_OPCODE    = 4'hF;
    localparam logic [CNT_W-1:0] CNT_RESET     = 2'b00;
    localparam logic [CNT_W-1:0] CNT_MAX       = 2'b11;
    localparam logic [CNT_W-1:0] CNT_MIN       = 2'b00;
    localparam logic [PC_W-1:0]  PC_RESET      = 16'h0000;
    localparam logic [PC_W-1:0]  INSTR_BYTES   = 16'h0002;
    localparam logic [PC_W-1:0]  PC_ALIGN_MASK = 16'hFFFE;

    typedef enum logic [1:0] {
        NPC_REDIRECT,
        NPC_HOLD,
        NPC_TARGET,
        NPC_SEQ
    } npc_sel_e;

    // Two-bit saturating counter step toward the resolved outcome.
    function automatic logic [CNT_W-1:0] satCount(input logic [CNT_W-1:0] cnt,
                                                  input logic             taken);
        logic [CNT_W-1:0] result;
        result = cnt;
        if (taken) begin
            if (cnt != CNT_MAX) begin
                result = cnt + 2'd1;
            end
        end else if (cnt != CNT_MIN) begin
            result = cnt - 2'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fetch_unit_branch_predictor.sv
// Branch history table (2-bit counters) and branch target buffer with one
// combinational read port and one clocked update port.
module Branch_Predictor
    import fetch_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_counter,
    output logic [PC_W-1:0]  rd_target,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    input  logic [PC_W-1:0]  upd_target
);

    logic [CNT_W-1:0] bht_q [PRED_DEPTH];
    logic [CNT_W-1:0] bht_d [PRED_DEPTH];
    logic [PC_W-1:0]  btb_q [PRED_DEPTH];
    logic [PC_W-1:0]  btb_d [PRED_DEPTH];

    // Reads see registered state only, so a same-cycle update shows up next cycle.
    assign rd_counter = bht_q[rd_idx];
    assign rd_target  = btb_q[rd_idx];

    always_comb begin
        bht_d = bht_q;
        btb_d = btb_q;
        if (upd_en) begin
            bht_d[upd_idx] = satCount(bht_q[upd_idx], upd_taken);
            if (upd_taken) begin
                btb_d[upd_idx] = upd_target;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < PRED_DEPTH; i++) begin
                bht_q[i] <= CNT_RESET;
                btb_q[i] <= PC_RESET;
            end
        end else begin
            bht_q <= bht_d;
            btb_q <= btb_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, next-PC selection (redirect, stall,
// halt, predicted-taken, sequential) and the branch predictor.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            upd_en,
    input  logic [3:0]      upd_idx,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    input  logic [PC_W-1:0] imem_data,
    output logic [PC_W-1:0] imem_addr,
    output logic [PC_W-1:0] PC_curr,
    output logic [PC_W-1:0] PC_next,
    output logic [PC_W-1:0] PC_inst,
    output logic [1:0]      prediction,
    output logic [PC_W-1:0] predicted_target,
    output logic            halted
);

    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  pc_d;
    logic [PC_W-1:0]  pcSeq;
    logic [CNT_W-1:0] predCounter;
    logic [PC_W-1:0]  predTarget;
    logic [IDX_W-1:0] predIdx;
    logic [IDX_W-1:0] updEntry;
    logic             hltFetched;
    logic             predictTaken;
    logic             unusedUpdLsb;
    npc_sel_e         npcSel;

    // Instructions are two bytes, so the index skips PC bit 0.
    assign predIdx      = pc_q[IDX_W:1];
    assign updEntry     = upd_idx[IDX_W:1];
    assign unusedUpdLsb = upd_idx[0];

    assign pcSeq        = pc_q + INSTR_BYTES;
    assign hltFetched   = (imem_data[PC_W-1 -: OPC_W] == HLT_OPCODE);
    assign predictTaken = predCounter[CNT_W-1];

    assign imem_addr        = pc_q;
    assign PC_curr          = pc_q;
    assign PC_next          = pcSeq;
    assign PC_inst          = imem_data;
    assign prediction       = predCounter;
    assign predicted_target = predTarget;
    assign halted           = hltFetched & ~redirect;

    Branch_Predictor u_predictor (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_idx     (predIdx),
        .rd_counter (predCounter),
        .rd_target  (predTarget),
        .upd_en     (upd_en),
        .upd_idx    (updEntry),
        .upd_taken  (upd_taken),
        .upd_target (upd_target)
    );

    // A redirect means the HLT was fetched on a wrong path, so it beats the halt hold.
    always_comb begin
        npcSel = NPC_SEQ;
        if (redirect) begin
            npcSel = NPC_REDIRECT;
        end else if (stall || hltFetched) begin
            npcSel = NPC_HOLD;
        end else if (predictTaken) begin
            npcSel = NPC_TARGET;
        end
    end

    always_comb begin
        pc_d = pcSeq;
        case (npcSel)
            NPC_REDIRECT: pc_d = redirect_pc;
            NPC_HOLD:     pc_d = pc_q;
            NPC_TARGET:   pc_d = predTarget;
            default:      pc_d = pcSeq;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_d & PC_ALIGN_MASK;
        end
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, synchronous, active-low.
REQ-003 stall  input  1  hold PC (load-use/structural stall from hazard unit).
REQ-004 redirect  input  1  branch resolved as mispredicted in decode; load redirect_pc.
REQ-005 redirect_pc  input  16  correct fetch address on redirect.
REQ-006 upd_en  input  1  predictor update valid (branch resolved in decode).
REQ-007 upd_idx  input  4  lower 4 PC bits of the resolved branch.
REQ-008 upd_taken  input  1  actual branch outcome.
REQ-009 upd_target  input  16  actual branch target.
REQ-010 imem_data  input  16  instruction word at imem_addr, combinational read.
REQ-011 imem_addr  output  16  current fetch address, equal to PC_curr.
REQ-012 PC_curr  output  16  address of the instruction being fetched.
REQ-013 PC_next  output  16  PC_curr + 2, modulo 2^16.
REQ-014 PC_inst  output  16  fetched instruction word, equal to imem_data.
REQ-015 prediction  output  2  BHT counter for PC_curr.
REQ-016 predicted_target  output  16  BTB entry for PC_curr.
REQ-017 halted  output  1  high while the fetch of a HLT (opcode 4'hF) freezes the PC.

Function
REQ-018 PC register 16 bits, byte-addressed; instructions 2 bytes; PC[0] always 0.
REQ-019 index = PC_curr[3:1]; BHT = 8 x 2-bit saturating counters; BTB = 8 x 16-bit targets.
REQ-020 prediction, predicted_target: combinational reads of BHT/BTB at index; zero-cycle latency.
REQ-021 predict taken iff prediction[1] == 1.
REQ-022 Next-PC priority (highest first): redirect -> redirect_pc; stall -> hold; HLT fetched (PC_inst[15:12] == 4'hF) -> hold; predict taken -> predicted_target; otherwise PC_next.
REQ-023 redirect with stall asserted in the same cycle: redirect wins.
REQ-024 redirect while halted: PC loads redirect_pc and halted clears the next cycle (HLT was on the wrong path).
REQ-025 halted = (PC_inst[15:12] == 4'hF) & ~redirect; combinational.
REQ-026 Update on upd_en at the clock edge, entry upd_idx[3:1]: counter +1 saturating at 2'b11 if upd_taken, else -1 saturating at 2'b00; BTB entry <= upd_target only when upd_taken.
REQ-027 Updates are not gated by stall or halted.
REQ-028 Update and fetch to the same index in one cycle: fetch reads the old value; the new value is visible the following cycle.
REQ-029 PC_next wraps: 16'hFFFE + 2 = 16'h0000; a predicted target is used unmodified.

Reset
REQ-030 rst_n low at a clock edge: PC <= 16'h0000, all BHT entries <= 2'b00, all BTB entries <= 16'h0000.
REQ-031 Reset overrides redirect, stall and upd_en in the same cycle.
REQ-032 Outputs immediately after reset: PC_curr = 0, PC_next = 2, prediction = 0, predicted_target = 0; halted and PC_inst follow imem_data.

Structure
REQ-033 Shared package/header holds: PC width 16, BHT/BTB depth 8, index width 3, HLT opcode 4'hF, counter reset value 2'b00.
REQ-034 A single sub-module Branch_Predictor SHALL contain the BHT, the BTB, the read port and the update port; the PC and the next-PC mux stay in fetch_unit.
REQ-035 Storage SHALL use the existing CPU_Register cells, or equivalent flops with synchronous reset.

Verification
REQ-036 Reset, then 4 cycles with imem_data = 16'h0000 and no stall -> PC_curr = 0, 2, 4, 6; prediction = 0 throughout.
REQ-037 Three upd_en with upd_idx = 4'h4, upd_taken = 1, upd_target = 16'h0040, then fetch at PC = 4 -> prediction sequence 01, 10, 11, 11; PC_curr = 16'h0040 the next cycle.
REQ-038 Counter at 11 for idx 4; two not-taken updates -> counter 01; fetch at PC = 4 goes to 6.
REQ-039 stall = 1 and redirect = 1 with redirect_pc = 16'h0100 in the same cycle -> PC_curr = 16'h0100 the next cycle.
REQ-040 imem_data = 16'hF000 at PC = 8 -> halted = 1 and PC holds at 8 for 5 cycles; then redirect to 16'h0020 -> PC_curr = 16'h0020, halted = 0.
REQ-041 PC = 16'hFFFE, not taken -> PC_next = 0; next PC_curr = 0. Assert rst_n low mid-run -> all state is cleared per REQ-030.
